// File: rtl/pulse_cmd_pkg.sv
// Shared definitions for the pulse command decoder / register file.
//   state_t            : frame handling phases. The serialiser reuses S_RX as
//                        its idle phase and owns S_TX_LOAD / S_TX_WAIT.
//   CTRL_READ_BIT      : control-byte bit selecting read (1) or write (0)
//   NAK_BYTE           : single-byte reply for an out-of-range address
//   MAX_PAYLOAD_BYTES  : largest supported payload size
//   byte_sum()         : mod-256 sum of the low n bytes of a payload word
package pulse_cmd_pkg;

   typedef enum logic [1:0] {
      S_RX      = 2'd0,
      S_EXEC    = 2'd1,
      S_TX_LOAD = 2'd2,
      S_TX_WAIT = 2'd3
   } state_t;

   localparam int         CTRL_READ_BIT     = 7;
   localparam logic [7:0] NAK_BYTE          = 8'hEE;
   localparam int         MAX_PAYLOAD_BYTES = 8;

   function automatic logic [7:0] byte_sum(input logic [8*MAX_PAYLOAD_BYTES-1:0] data,
                                           input int n);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
         if (k < n) acc = acc + data[8*k +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/pulse_cmd_regfile_if.sv
// UART-facing byte interface of the pulse command register file.
//   rx_valid / rx_byte : received byte from the uart (valid held >= 1 cycle)
//   tx_busy            : uart transmitter is shifting a byte out
//   tx_start / tx_byte : one-cycle transmit request and the byte to send
// Modports: master = uart side, slave = command decoder side.
interface pulse_cmd_regfile_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_byte;

   modport master (output rx_valid, output rx_byte, output tx_busy,
                   input  tx_start, input  tx_byte);
   modport slave  (input  rx_valid, input  rx_byte, input  tx_busy,
                   output tx_start, output tx_byte);
endinterface

// File: rtl/pulse_cmd_tx_seq.sv
// Reply serialiser: captures up to PAYLOAD_BYTES+1 reply bytes plus a count on
// load, then hands them to the uart one at a time, LSB-slot first.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture reply_bytes / reply_cnt (honoured only when idle)
//   reply_bytes  : byte k in bits [8k +: 8]
//   reply_cnt    : number of valid reply bytes (>= 1)
//   tx_busy      : uart transmitter busy
//   tx_start     : one-cycle transmit request, tx_byte valid with it
//   done         : one-cycle pulse when the last byte has been shifted out
module pulse_cmd_tx_seq
   import pulse_cmd_pkg::*;
#(
   parameter  int PAYLOAD_BYTES = 4,
   localparam int NB            = PAYLOAD_BYTES + 1,
   localparam int CNT_W         = $clog2(NB + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [8*NB-1:0]   reply_bytes,
   input  logic [CNT_W-1:0]  reply_cnt,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_byte,
   output logic              done
);

   state_t           st_reg, st_next;
   logic [7:0]       bytes_reg [NB];
   logic [CNT_W-1:0] idx_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             gap_reg;
   logic             last;
   logic             wait_over;
   logic             capture;

   assign capture   = (st_reg == S_RX) && load;
   assign last      = (idx_reg + 1'b1) == cnt_reg;
   // The uart raises tx_busy one cycle after tx_start, so the first
   // S_TX_WAIT cycle (gap_reg set) must not read tx_busy.
   assign wait_over = (st_reg == S_TX_WAIT) && !gap_reg && !tx_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_reg <= S_RX;
      else     st_reg <= st_next;
   end

   always_comb begin
      st_next = st_reg;
      case (st_reg)
         S_RX:      if (load)     st_next = S_TX_LOAD;
         S_TX_LOAD: if (!tx_busy) st_next = S_TX_WAIT;
         S_TX_WAIT: if (wait_over) st_next = last ? S_RX : S_TX_LOAD;
         default:                 st_next = S_RX;
      endcase
   end

   always_comb begin
      tx_start = (st_reg == S_TX_LOAD) && !tx_busy;
      tx_byte  = tx_start ? bytes_reg[idx_reg] : 8'h00;
      done     = wait_over && last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg <= '0;
         cnt_reg <= '0;
         gap_reg <= 1'b0;
      end else begin
         gap_reg <= tx_start;
         if (capture) begin
            idx_reg <= '0;
            cnt_reg <= reply_cnt;
         end else if (wait_over && !last) begin
            idx_reg <= idx_reg + 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         always_ff @(posedge clk or posedge rst) begin
            if (rst)          bytes_reg[gi] <= 8'h00;
            else if (capture) bytes_reg[gi] <= reply_bytes[8*gi +: 8];
         end
      end
   endgenerate

endmodule

// File: rtl/pulse_cmd_regfile.sv
// UART command decoder and register file for the pulse generator.
// Frames are PAYLOAD_BYTES little-endian payload bytes followed by a control
// byte (bit7 read/write, bits[6:0] address). Writes load a register and reply
// with the payload checksum; reads reply with the register bytes plus their
// checksum; out-of-range addresses reply NAK (8'hEE).
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : uart byte interface (slave modport)
//   regs_flat   : register i in bits [i*REG_W +: REG_W]
//   reg_wr_stb  : one-cycle strobe for the register being written
//   frame_done  : one-cycle pulse when a reply has been fully sent
//   frame_err   : one-cycle pulse on a dropped byte or timed-out frame
// Optional feature: define PULSE_CMD_TIMEOUT_EN to discard a partial frame
// after TIMEOUT_CYC idle cycles; otherwise a partial frame waits forever.
module pulse_cmd_regfile
   import pulse_cmd_pkg::*;
#(
   parameter int                          NUM_REGS      = 16,
   parameter int                          REG_W         = 32,
   parameter int                          PAYLOAD_BYTES = 4,
   parameter logic [NUM_REGS*REG_W-1:0]   RESET_VALS    = '0,
   parameter int                          TIMEOUT_CYC   = 5000000
) (
   input  logic                        clk,
   input  logic                        rst,
   pulse_cmd_regfile_if.slave          bus,
   output logic [NUM_REGS*REG_W-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]         reg_wr_stb,
   output logic                        frame_done,
   output logic                        frame_err
);

   localparam int NB     = PAYLOAD_BYTES + 1;
   localparam int CNT_W  = $clog2(NB + 1);
   localparam int BCNT_W = $clog2(PAYLOAD_BYTES + 1);
   localparam int MAXW   = 8 * MAX_PAYLOAD_BYTES;

   // At this level S_TX_LOAD covers the whole reply; the serialiser tracks
   // the load/wait phases itself.
   state_t                  state_reg, state_next;
   logic                    rx_valid_d_reg;
   logic                    rx_edge;
   logic                    rx_accept;
   logic                    ctrl_arrives;
   logic [BCNT_W-1:0]       byte_cnt_reg;
   logic [8*PAYLOAD_BYTES-1:0] payload_reg;
   logic [7:0]              ctrl_reg;
   logic [REG_W-1:0]        regs_reg [NUM_REGS];
   logic [6:0]              addr;
   logic                    addr_ok;
   logic                    is_read;
   logic                    wr_en;
   logic                    tx_load;
   logic                    tx_done;
   logic                    timeout;
   logic [REG_W-1:0]        rd_data;
   logic [MAXW-1:0]         payload_ext;
   logic [MAXW-1:0]         rd_ext;
   logic [7:0]              pl_sum;
   logic [7:0]              rd_sum;
   logic [8*NB-1:0]         reply_bytes;
   logic [CNT_W-1:0]        reply_cnt;

   // A byte counts once per rising edge of rx_valid, however long it is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_valid_d_reg <= 1'b0;
      else     rx_valid_d_reg <= bus.rx_valid;
   end

   assign rx_edge      = bus.rx_valid && !rx_valid_d_reg;
   assign rx_accept    = rx_edge && (state_reg == S_RX);
   assign ctrl_arrives = rx_accept && (byte_cnt_reg == BCNT_W'(PAYLOAD_BYTES));

   assign addr    = ctrl_reg[6:0];
   assign is_read = ctrl_reg[CTRL_READ_BIT];
   assign addr_ok = {1'b0, addr} < 8'(NUM_REGS);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_RX;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RX:                 if (ctrl_arrives) state_next = S_EXEC;
         S_EXEC:               state_next = S_TX_LOAD;
         S_TX_LOAD, S_TX_WAIT: if (tx_done) state_next = S_RX;
         default:              state_next = S_RX;
      endcase
   end

   always_comb begin
      tx_load    = (state_reg == S_EXEC);
      wr_en      = (state_reg == S_EXEC) && !is_read && addr_ok;
      // Any byte edge outside S_RX is dropped, including one that coincides
      // with the final tx completion.
      frame_err  = (rx_edge && (state_reg != S_RX)) || timeout;
      frame_done = tx_done;
   end

   // ---------------- frame assembly ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_reg <= '0;
         ctrl_reg     <= 8'h00;
      end else if (rx_accept) begin
         if (byte_cnt_reg == BCNT_W'(PAYLOAD_BYTES)) begin
            byte_cnt_reg <= '0;
            ctrl_reg     <= bus.rx_byte;
         end else begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
         end
      end else if (timeout) begin
         byte_cnt_reg <= '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               payload_reg[8*gi +: 8] <= 8'h00;
            else if (rx_accept && (byte_cnt_reg == BCNT_W'(gi)))
               payload_reg[8*gi +: 8] <= bus.rx_byte;
         end
      end
   endgenerate

`ifdef PULSE_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_reg;
   logic            to_armed;

   // Runs only while a partial frame is pending; every accepted byte restarts it.
   assign to_armed = (state_reg == S_RX) && (byte_cnt_reg != '0) && !rx_edge;
   assign timeout  = to_armed && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        to_cnt_reg <= '0;
      else if (!to_armed || timeout)  to_cnt_reg <= '0;
      else                            to_cnt_reg <= to_cnt_reg + 1'b1;
   end
`else
   // Timeout disabled: a partial frame waits indefinitely and TIMEOUT_CYC
   // has no effect in this build.
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   // ---------------- register bank ----------------
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign reg_wr_stb[gi] = wr_en && (addr == 7'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst)                 regs_reg[gi] <= RESET_VALS[gi*REG_W +: REG_W];
            else if (reg_wr_stb[gi]) regs_reg[gi] <= payload_reg[REG_W-1:0];
         end

         assign regs_flat[gi*REG_W +: REG_W] = regs_reg[gi];
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == 7'(i)) rd_data = regs_reg[i];
      end
   end

   // ---------------- reply build ----------------
   always_comb begin
      payload_ext = '0;
      payload_ext[8*PAYLOAD_BYTES-1:0] = payload_reg;
      rd_ext = '0;
      rd_ext[REG_W-1:0] = rd_data;
      pl_sum = byte_sum(payload_ext, PAYLOAD_BYTES);
      rd_sum = byte_sum(rd_ext, PAYLOAD_BYTES);

      reply_bytes = '0;
      reply_cnt   = CNT_W'(1);
      if (!addr_ok) begin
         reply_bytes[7:0] = NAK_BYTE;
      end else if (is_read) begin
         reply_bytes = {rd_sum, rd_ext[8*PAYLOAD_BYTES-1:0]};
         reply_cnt   = CNT_W'(NB);
      end else begin
         reply_bytes[7:0] = pl_sum;
      end
   end

   pulse_cmd_tx_seq #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES)
   ) u_tx_seq (
      .clk         (clk),
      .rst         (rst),
      .load        (tx_load),
      .reply_bytes (reply_bytes),
      .reply_cnt   (reply_cnt),
      .tx_busy     (bus.tx_busy),
      .tx_start    (bus.tx_start),
      .tx_byte     (bus.tx_byte),
      .done        (tx_done)
   );

endmodule

// File: tb/tb_pulse_cmd_regfile.sv
// Self-checking bench for pulse_cmd_regfile (16 x 32-bit registers, 4-byte
// payload, 1000-cycle timeout). A behavioural uart model answers tx_start
// with a random-length busy period; a monitor collects reply bytes, strobes
// and pulses, which each scenario task compares against a register model.
module tb_pulse_cmd_regfile;

   localparam int NR = 16;
   localparam int RW = 32;
   localparam int PB = 4;
   localparam int TO = 1000;

   function automatic logic [NR*RW-1:0] mk_rst_vals();
      logic [NR*RW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*RW +: RW] = 32'hC0DE_0000 + 32'(i) * 32'h111;
      return v;
   endfunction

   localparam logic [NR*RW-1:0] RST_VALS = mk_rst_vals();

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pulse_cmd_regfile_if bus ();
   logic [NR*RW-1:0] regs_flat;
   logic [NR-1:0]    reg_wr_stb;
   logic             frame_done;
   logic             frame_err;

   pulse_cmd_regfile #(
      .NUM_REGS      (NR),
      .REG_W         (RW),
      .PAYLOAD_BYTES (PB),
      .RESET_VALS    (RST_VALS),
      .TIMEOUT_CYC   (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .regs_flat  (regs_flat),
      .reg_wr_stb (reg_wr_stb),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]   model_regs [NR];
   logic [7:0]    exp_q[$];
   logic [NR-1:0] exp_stb_q[$];

   logic [7:0]    reply_q[$];
   logic [NR-1:0] stb_q[$];
   int done_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int last_rx_cyc = 0;
   int first_lat = -1;
   logic rx_prev = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: samples DUT outputs on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rx_prev = 1'b0;
      end else begin
         if (bus.rx_valid && !rx_prev) last_rx_cyc = cyc;
         rx_prev = bus.rx_valid;
         if (bus.tx_start) begin
            if (reply_q.size() == 0 && first_lat < 0) first_lat = cyc - last_rx_cyc;
            reply_q.push_back(bus.tx_byte);
         end
         if (frame_done) done_cnt++;
         if (frame_err) err_cnt++;
         if (reg_wr_stb != '0) stb_q.push_back(reg_wr_stb);
      end
   end

   // UART transmitter model: busy rises one cycle after tx_start.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [NR*RW-1:0] model_flat();
      logic [NR*RW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*RW +: RW] = model_regs[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) model_regs[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;
   endtask

   // Reference behaviour of one complete frame.
   task automatic model_apply(input logic [31:0] pl, input logic [7:0] ctrl);
      int addr;
      int s;
      logic [31:0] v;
      exp_q.delete();
      exp_stb_q.delete();
      addr = int'(ctrl[6:0]);
      s = 0;
      if (addr >= NR) begin
         exp_q.push_back(8'hEE);
      end else if (ctrl[7]) begin
         v = model_regs[addr];
         for (int k = 0; k < PB; k++) begin
            exp_q.push_back(v[8*k +: 8]);
            s += int'(v[8*k +: 8]);
         end
         exp_q.push_back(8'(s % 256));
      end else begin
         for (int k = 0; k < PB; k++) s += int'(pl[8*k +: 8]);
         model_regs[addr] = pl;
         exp_stb_q.push_back(NR'(1) << addr);
         exp_q.push_back(8'(s % 256));
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clk);
      #1;
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Sends bytes start_idx..PB of a frame, optionally injects a stray byte
   // during the reply, then checks reply, strobes, pulses and registers.
   task automatic run_frame(input string name, input logic [31:0] pl, input logic [7:0] ctrl,
                            input int hold, input bit inject, input int start_idx);
      int d0;
      int e0;
      int n;
      reply_q.delete();
      stb_q.delete();
      first_lat = -1;
      d0 = done_cnt;
      e0 = err_cnt;
      model_apply(pl, ctrl);
      for (int k = start_idx; k < PB; k++) send_byte(pl[8*k +: 8], hold);
      send_byte(ctrl, hold);
      if (inject) begin
         for (int i = 0; i < 2000 && reply_q.size() == 0; i++) @(posedge clk);
         send_byte(8'h55, 1);
      end
      for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;

      vectors++;
      if (done_cnt - d0 !== 1) begin
         miscompares++;
         $display("FAIL %s frame_done: got %0d pulses expected 1", name, done_cnt - d0);
      end
      vectors++;
      if (err_cnt - e0 !== (inject ? 1 : 0)) begin
         miscompares++;
         $display("FAIL %s frame_err: got %0d pulses expected %0d", name, err_cnt - e0, inject ? 1 : 0);
      end
      vectors++;
      if (reply_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL %s reply length: got %0d expected %0d", name, reply_q.size(), exp_q.size());
      end
      n = (reply_q.size() < exp_q.size()) ? reply_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (reply_q[k] !== exp_q[k]) begin
            miscompares++;
            $display("FAIL %s reply byte %0d: got %02h expected %02h", name, k, reply_q[k], exp_q[k]);
         end
      end
      vectors++;
      if (stb_q.size() !== exp_stb_q.size()) begin
         miscompares++;
         $display("FAIL %s strobe cycles: got %0d expected %0d", name, stb_q.size(), exp_stb_q.size());
      end else if (stb_q.size() == 1) begin
         vectors++;
         if (stb_q[0] !== exp_stb_q[0]) begin
            miscompares++;
            $display("FAIL %s reg_wr_stb: got %04h expected %04h", name, stb_q[0], exp_stb_q[0]);
         end
      end
      vectors++;
      if (regs_flat !== model_flat()) begin
         miscompares++;
         $display("FAIL %s regs_flat: got %h expected %h", name, regs_flat, model_flat());
      end
      vectors++;
      if (first_lat < 2) begin
         miscompares++;
         $display("FAIL %s reply latency: got %0d cycles expected >= 2", name, first_lat);
      end
      $display("frame %s ctrl=%02h payload=%08h reply_len=%0d", name, ctrl, pl, reply_q.size());
   endtask

   task automatic check_reset_state(input string name);
      @(negedge clk);
      vectors++;
      if (regs_flat !== RST_VALS) begin
         miscompares++;
         $display("FAIL %s regs_flat: got %h expected %h", name, regs_flat, RST_VALS);
      end
      vectors++;
      if ({bus.tx_start, reg_wr_stb, frame_done, frame_err} !== '0) begin
         miscompares++;
         $display("FAIL %s outputs: got tx_start=%b stb=%04h done=%b err=%b expected all 0",
                  name, bus.tx_start, reg_wr_stb, frame_done, frame_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("reset applied and released");
   endtask

   task automatic test_write_read();
      run_frame("write_reg2", 32'h12345678, 8'h02, 1, 1'b0, 0);
      run_frame("read_reg2",  32'h00000000, 8'h82, 1, 1'b0, 0);
   endtask

   task automatic test_nak();
      run_frame("nak_addr16",  32'h04030201, 8'h10, 1, 1'b0, 0);
      run_frame("nak_read127", 32'hDEADBEEF, 8'hFF, 2, 1'b0, 0);
   endtask

   task automatic test_long_hold();
      run_frame("hold20_write", 32'h12345678, 8'h02, 20, 1'b0, 0);
   endtask

   task automatic test_drop_during_reply();
      run_frame("drop_in_reply", 32'h0, 8'h82, 1, 1'b1, 0);
      run_frame("after_drop", 32'hA5A5_0F0F, 8'h05, 1, 1'b0, 0);
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      reply_q.delete();
      send_byte(8'h78, 1);
      send_byte(8'h56, 1);
`ifdef PULSE_CMD_TIMEOUT_EN
      repeat (TO - 20) @(posedge clk);
      #1;
      vectors++;
      if (err_cnt - e0 !== 0) begin
         miscompares++;
         $display("FAIL timeout_early: got %0d frame_err expected 0", err_cnt - e0);
      end
      repeat (40) @(posedge clk);
      #1;
      vectors++;
      if (err_cnt - e0 !== 1 || reply_q.size() !== 0) begin
         miscompares++;
         $display("FAIL timeout_fire: got err=%0d reply=%0d expected err=1 reply=0",
                  err_cnt - e0, reply_q.size());
      end
      $display("timeout partial frame discarded");
      run_frame("after_timeout", 32'h12345678, 8'h02, 1, 1'b0, 0);
`else
      repeat (TO + 100) @(posedge clk);
      #1;
      vectors++;
      if (err_cnt - e0 !== 0 || reply_q.size() !== 0) begin
         miscompares++;
         $display("FAIL no_timeout_idle: got err=%0d reply=%0d expected err=0 reply=0",
                  err_cnt - e0, reply_q.size());
      end
      $display("partial frame held across idle period");
      run_frame("resume_partial", 32'h12345678, 8'h02, 1, 1'b0, 2);
`endif
   endtask

   task automatic test_reset_midframe();
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      send_byte(8'h33, 1);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      check_reset_state("rst_midframe");
      @(posedge clk);
      #1 rst = 1'b0;
      run_frame("after_rst_frame", 32'h12345678, 8'h02, 1, 1'b0, 0);
   endtask

   task automatic test_reset_midreply();
      reply_q.delete();
      for (int k = 0; k < PB; k++) send_byte(8'h00, 1);
      send_byte(8'h82, 1);
      for (int i = 0; i < 2000 && reply_q.size() < 2; i++) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      check_reset_state("rst_midreply");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      run_frame("read_after_rst", 32'h0, 8'h82, 1, 1'b0, 0);
   endtask

   task automatic test_random();
      logic [31:0] pl;
      logic [7:0]  ctrl;
      for (int t = 0; t < 30; t++) begin
         pl   = $urandom;
         ctrl = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
         run_frame($sformatf("rand%0d", t), pl, ctrl, $urandom_range(1, 4), 1'b0, 0);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_nak();
      test_long_hold();
      test_drop_during_reply();
      test_timeout();
      test_reset_midframe();
      test_reset_midreply();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
